// File: rtl/dm_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM states
// and a constant-function helper for address width derivation.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dm_state_e;

    function automatic int unsigned log2ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane logic: store byte-enables and merged word, load
// lane extraction with sign/zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [31:0] wlane;
    logic [31:0] shifted;

    assign shifted = word_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o     = '0;
        wlane    = '0;
        load_o   = '0;
        merged_o = word_i;
        unique case (size_i)
            SZ_BYTE: begin
                be_o   = 4'b0001 << addr_lo_i;
                wlane  = {4{wdata_i[7:0]}};
                load_o = unsigned_i ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wlane  = {2{wdata_i[15:0]}};
                load_o = unsigned_i ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be_o   = 4'b1111;
                wlane  = wdata_i;
                load_o = word_i;
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_o[i]) merged_o[8*i +: 8] = wlane[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller with fixed response latency.
// Define DM_TRACE_EN to print a trace line for every legal store.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW        = (log2ceil(DEPTH_WORDS) < 1) ? 1 : log2ceil(DEPTH_WORDS);
    localparam logic [2:0]  CNT_INIT  = 3'(LATENCY - 1);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];
    dm_state_e   state_q;
    logic [2:0]  cnt_q;
    logic        ready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        rerr_q;
    logic [31:0] pend_data_q;
    logic        pend_err_q;

    logic [AW-1:0] idx;
    logic          in_range;
    logic          err;
    logic          accept;
    logic [31:0]   word_rd;
    logic [3:0]    be;
    logic [31:0]   merged;
    logic [31:0]   load_ext;
    logic [31:0]   load_res;

    // Full upper address takes part in the range check so aliases are rejected.
    assign idx      = req_addr[AW+1:2];
    assign in_range = req_addr[31:2] < DEPTH_LIM;
    assign err      = (req_size == 2'd3)
                    | ((req_size == SZ_HALF) & req_addr[0])
                    | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                    | ~in_range;
    assign word_rd  = in_range ? mem_q[idx] : '0;
    assign load_res = (req_we | err) ? '0 : load_ext;
    assign accept   = req_valid & req_ready;

    assign req_ready  = ready_q & ~reset;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

    dm_lane_align u_align (
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .addr_lo_i  (req_addr[1:0]),
        .wdata_i    (req_wdata),
        .word_i     (word_rd),
        .be_o       (be),
        .merged_o   (merged),
        .load_o     (load_ext)
    );

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^{req_pc, be};
`else
    logic unused_be;
    assign unused_be = ^be;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_we && !err) begin
                            mem_q[idx] <= merged;
`ifdef DM_TRACE_EN
                            $display("%d@%h: *%h <= %h", $time, req_pc,
                                     {req_addr[31:2], 2'b00}, merged);
`endif
                        end
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q  <= ST_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= load_res;
                            rerr_q   <= err;
                        end else begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= CNT_INIT;
                            pend_data_q <= load_res;
                            pend_err_q  <= err;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q  <= ST_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= pend_data_q;
                        rerr_q   <= pend_err_q;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        rvalid_q <= 1'b0;
                        rdata_q  <= '0;
                        rerr_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
